alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : 32-bit ALU execution unit with a valid/ready request port and
//               a valid/ready result port. Logic, arithmetic and compare
//               operations complete in one cycle. Shifts either iterate one
//               bit per cycle through the SHIFT state (default build) or use a
//               single-cycle barrel shifter when ALU_FAST_SHIFT_EN is defined.
//               Result and flags are registered and held in DONE until the
//               consumer accepts them.
// Config      : `define ALU_FAST_SHIFT_EN -> single-cycle barrel shifts
// Revision    : 1.0  initial release
// ============================================================================
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_sel,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        carry,
  output logic        overflow,
  output logic        sign
);

  // Operation codes from the ALU control unit
  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_XOR  = 4'b0011;
  localparam logic [3:0] c_OP_SLT  = 4'b0100;
  localparam logic [3:0] c_OP_SLTU = 4'b0101;
  localparam logic [3:0] c_OP_SUB  = 4'b0110;
  localparam logic [3:0] c_OP_SRL  = 4'b0111;
  localparam logic [3:0] c_OP_SRA  = 4'b1000;
  localparam logic [3:0] c_OP_SLL  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Captured operation and iterative shift working state
  logic [3:0]  r_op;
  logic [31:0] r_work;
  logic [4:0]  r_cnt;

  // Registered outputs
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_carry;
  logic        r_overflow;
  logic        r_sign;

  // Single-cycle datapath
  logic [4:0]  w_shamt;
  logic        w_is_shift;
  logic        w_go_shift;
  logic        w_xfer;
  logic        w_is_sub;
  logic [31:0] w_b_eff;
  logic [32:0] w_sum33;
  logic        w_add_ovf;
  logic [31:0] w_res;
  logic        w_res_c;
  logic        w_res_v;

  // Iterative shift datapath
  logic [31:0] w_work_nxt;
  logic        w_last_shift;

  assign w_shamt    = op_b[4:0];
  assign w_is_shift = (alu_sel == c_OP_SRL) || (alu_sel == c_OP_SRA) ||
                      (alu_sel == c_OP_SLL);
  assign w_xfer     = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN
  // Barrel shifter handles every shift in one cycle; SHIFT is never entered
  assign w_go_shift = 1'b0;
`else
  // Only a non-zero shift amount needs the iterative path
  assign w_go_shift = w_is_shift && (w_shamt != 5'd0);
`endif

  // SUB reuses the adder as a + ~b + 1 so carry/overflow fall out of one sum
  assign w_is_sub  = (alu_sel == c_OP_SUB);
  assign w_b_eff   = w_is_sub ? ~op_b : op_b;
  assign w_sum33   = {1'b0, op_a} + {1'b0, w_b_eff} + {32'd0, w_is_sub};
  assign w_add_ovf = (op_a[31] == w_b_eff[31]) && (w_sum33[31] != op_a[31]);

  // Single-cycle operation result and arithmetic flags from the live inputs
  always_comb begin
    w_res   = 32'd0;
    w_res_c = 1'b0;
    w_res_v = 1'b0;
    case (alu_sel)
      c_OP_AND:  w_res = op_a & op_b;
      c_OP_OR:   w_res = op_a | op_b;
      c_OP_XOR:  w_res = op_a ^ op_b;
      c_OP_ADD,
      c_OP_SUB: begin
        w_res   = w_sum33[31:0];
        w_res_c = w_sum33[32];
        w_res_v = w_add_ovf;
      end
      c_OP_SLT:  w_res = {31'd0, ($signed(op_a) < $signed(op_b))};
      c_OP_SLTU: w_res = {31'd0, (op_a < op_b)};
`ifdef ALU_FAST_SHIFT_EN
      c_OP_SRL:  w_res = op_a >> w_shamt;
      c_OP_SRA:  w_res = $signed(op_a) >>> w_shamt;
      c_OP_SLL:  w_res = op_a << w_shamt;
`else
      // Reached only with a zero shift amount: the source passes through
      c_OP_SRL,
      c_OP_SRA,
      c_OP_SLL:  w_res = op_a;
`endif
      default:   w_res = 32'd0;
    endcase
  end

  // One-bit shift step of the working register, direction from captured op
  always_comb begin
    w_work_nxt = r_work;
    case (r_op)
      c_OP_SRL: w_work_nxt = {1'b0, r_work[31:1]};
      c_OP_SRA: w_work_nxt = {r_work[31], r_work[31:1]};
      c_OP_SLL: w_work_nxt = {r_work[30:0], 1'b0};
      default:  w_work_nxt = r_work;
    endcase
  end

  assign w_last_shift = (r_cnt == 5'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = w_go_shift ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (w_last_shift) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iterative shifting and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= 4'd0;
      r_work     <= 32'd0;
      r_cnt      <= 5'd0;
      r_result   <= 32'd0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_sign     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_op <= alu_sel;
            if (w_go_shift) begin
              r_work <= op_a;
              r_cnt  <= w_shamt;
            end else begin
              r_result   <= w_res;
              r_zero     <= (w_res == 32'd0);
              r_carry    <= w_res_c;
              r_overflow <= w_res_v;
              r_sign     <= w_res[31];
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_work_nxt;
          r_cnt  <= r_cnt - 5'd1;
          if (w_last_shift) begin
            r_result   <= w_work_nxt;
            r_zero     <= (w_work_nxt == 32'd0);
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_sign     <= w_work_nxt[31];
          end
        end
        default: begin
          // DONE holds result and flags until the consumer accepts them
        end
      endcase
    end
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign sign     = r_sign;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Scoreboard bench for alu_exec_unit. A driver issues directed
//               and random requests and queues the reference model's answer;
//               a monitor pops and compares whenever out_valid is presented.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        sign;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {zero, carry, overflow, sign}
    int          lat;
    int          xfer;
    int          hold;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  alu_exec_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .sign      (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model straight from the operation definitions
  function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    longint sa, sb, ss, t;
    longint unsigned ua, ub;
    int sh;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    sh = int'(b[4:0]);
    c  = 1'b0;
    v  = 1'b0;
    ss = 0;
    t  = 0;
    case (sel)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd3: e.res = a ^ b;
      4'd2: begin
        e.res = a + b;
        c  = (ua + ub) > 64'hFFFF_FFFF;
        ss = sa + sb;
        v  = (ss != longint'(int'(ss)));
      end
      4'd6: begin
        e.res = a - b;
        c  = (ua >= ub);
        ss = sa - sb;
        v  = (ss != longint'(int'(ss)));
      end
      4'd4: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd5: e.res = (ua < ub) ? 32'd1 : 32'd0;
      4'd7: e.res = a >> sh;
      4'd8: begin
        t = sa >>> sh;
        e.res = t[31:0];
      end
      4'd9: e.res = a << sh;
      default: e.res = 32'd0;
    endcase
    e.flg = {(e.res == 32'd0), c, v, e.res[31]};
`ifdef ALU_FAST_SHIFT_EN
    e.lat = 1;
`else
    e.lat = ((sel == 4'd7 || sel == 4'd8 || sel == 4'd9) && sh != 0) ? sh + 1 : 1;
`endif
    e.xfer = 0;
    e.hold = 0;
    return e;
  endfunction

  // Present one request once in_ready is seen, queue the expected answer
  task automatic issue(input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    exp_t e;
    int   w;
    w = 0;
    while (in_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      chk("issue_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      alu_sel  = sel;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      e        = model(sel, a, b);
      e.xfer   = cyc + 1;
      e.hold   = hold;
      sbq.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      alu_sel  = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
    end
  endtask

  // Monitor: compare each presented result, check hold stability and release
  initial begin : monitor
    exp_t cur;
    bit   active;
    bit   release_pend;
    int   hold_cnt;
    active       = 0;
    release_pend = 0;
    hold_cnt     = 0;
    out_ready    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active       = 0;
        release_pend = 0;
        out_ready    = 1'b0;
      end else begin
        if (release_pend) begin
          chk("release_out_valid", {31'd0, out_valid}, 32'd0);
          chk("release_in_ready", {31'd0, in_ready}, 32'd1);
          release_pend = 0;
          active       = 0;
        end
        if (out_valid) begin
          if (!active) begin
            if (sbq.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_out_valid actual=1 required=0 at t=%0t", $time);
              cur.res  = result;
              cur.flg  = {zero, carry, overflow, sign};
              cur.hold = 0;
            end else begin
              cur = sbq.pop_front();
              chk("latency", 32'(cyc - cur.xfer + 1), 32'(cur.lat));
            end
            active   = 1;
            hold_cnt = cur.hold;
          end
          chk("result", result, cur.res);
          chk("flags_zcvs", {28'd0, zero, carry, overflow, sign}, {28'd0, cur.flg});
          chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
          if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
          end else begin
            out_ready = ($urandom_range(0, 2) != 0);
          end
          if (out_ready) release_pend = 1;
        end else begin
          // Asserted outside DONE, which the unit must ignore
          out_ready = ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  // Overall time bound
  initial begin : watchdog
    #2000000;
    total++;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Stimulus
  initial begin : driver
    int w;
    logic [3:0]  s;
    logic [31:0] a, b;
    rst      = 1'b0;
    in_valid = 1'b0;
    alu_sel  = 4'd0;
    op_a     = 32'd0;
    op_b     = 32'd0;
    #1 rst = 1'b1;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {28'd0, zero, carry, overflow, sign}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(4'b0010, 32'h7FFF_FFFF, 32'd1, 0);
    issue(4'b0110, 32'd5, 32'd5, 0);
    issue(4'b0101, 32'd1, 32'hFFFF_FFFF, 0);
    issue(4'b1000, 32'h8000_0000, 32'd4, 0);
`ifndef ALU_FAST_SHIFT_EN
    for (int k = 0; k < 4; k++) begin
      chk("shift_in_ready", {31'd0, in_ready}, 32'd0);
      chk("shift_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
`endif
    issue(4'b0010, 32'd9, 32'd10, 3);
    issue(4'b1111, $urandom, $urandom, 0);
    issue(4'b0111, 32'hF000_000F, 32'd0, 0);

    // Reset in the middle of a long shift
    issue(4'b1001, 32'h1234_5679, 32'd20, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_flags", {28'd0, zero, carry, overflow, sign}, 32'd0);
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    issue(4'b0010, 32'd2, 32'd3, 0);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      s = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 3));
      else                           b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      issue(s, a, b, $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drain outstanding results
    w = 0;
    while ((sbq.size() != 0 || out_valid) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_queue", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
